// File: rtl/mig_tt_sweeper.sv
// mig_tt_sweeper: steps a NUM_INPUTS-input network through every input vector,
// captures its truth table and scores it against an expected signature.
module mig_tt_sweeper #(
  parameter int NUM_INPUTS    = 7,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [(1<<NUM_INPUTS)-1:0]    expected_tt,
  output logic [NUM_INPUTS-1:0]         x_out,
  input  logic                          dut_out,
  output logic                          busy,
  output logic                          done,
  output logic [(1<<NUM_INPUTS)-1:0]    truth_table,
  output logic                          match,
  output logic [NUM_INPUTS:0]           mismatch_count,
  output logic [NUM_INPUTS-1:0]         first_mismatch_idx
);

  localparam int TT_W = 1 << NUM_INPUTS;
  localparam int SW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SW-1:0]         SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [SW-1:0]         SETTLE_ONE  = SW'(1);
  localparam logic [NUM_INPUTS-1:0] X_LAST      = '1;
  localparam logic [NUM_INPUTS-1:0] X_ONE       = NUM_INPUTS'(1);
  localparam logic [NUM_INPUTS:0]   CNT_ONE     = (NUM_INPUTS+1)'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // A zero settle time skips SETTLE entirely and samples back-to-back.
  localparam logic [1:0] VEC_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

  logic [1:0]      state;
  logic [SW-1:0]   settle_cnt;
  logic [TT_W-1:0] exp_q;
  logic            miss;

  assign miss = dut_out ^ exp_q[x_out];

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of x_out and mismatch_count within the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      settle_cnt         <= '0;
      exp_q              <= '0;
      x_out              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      truth_table        <= '0;
      match              <= 1'b0;
      mismatch_count     <= '0;
      first_mismatch_idx <= '0;
    end else begin
      // NOTE: done defaults low every cycle so it can only ever be a single-cycle pulse.
      done <= 1'b0;
      if (abort && (state == SETTLE || state == SAMPLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
        match <= 1'b0;
        x_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              exp_q              <= expected_tt;
              truth_table        <= '0;
              mismatch_count     <= '0;
              first_mismatch_idx <= '0;
              match              <= 1'b0;
              x_out              <= '0;
              settle_cnt         <= '0;
              busy               <= 1'b1;
              state              <= VEC_STATE;
            end
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state <= SAMPLE;
            end else begin
              settle_cnt <= settle_cnt + SETTLE_ONE;
            end
          end
          SAMPLE: begin
            truth_table[x_out] <= dut_out;
            if (miss) begin
              mismatch_count <= mismatch_count + CNT_ONE;
              if (mismatch_count == '0) begin
                first_mismatch_idx <= x_out;
              end
            end
            if (x_out == X_LAST) begin
              state <= FINISH;
            end else begin
              x_out      <= x_out + X_ONE;
              settle_cnt <= '0;
              state      <= VEC_STATE;
            end
          end
          FINISH: begin
            done  <= 1'b1;
            match <= (mismatch_count == '0);
            busy  <= 1'b0;
            x_out <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mig_tt_sweeper.sv
// Self-checking bench for mig_tt_sweeper: table-driven sweeps, randomized tables
// scored by a behavioural model, abort/reset corner cases and settle-time variants.
module tb_mig_tt_sweeper;
  localparam int N    = 7;
  localparam int TT_W = 1 << N;
  localparam logic [TT_W-1:0] GOLDEN = 128'heeeaeae8eea8e888eee8ea88e8a8a888;

  logic            clk;
  logic            rst_n;
  logic            start, abort, dut_out;
  logic [TT_W-1:0] expected_tt;
  logic [N-1:0]    x_out;
  logic            busy, done, match;
  logic [TT_W-1:0] truth_table;
  logic [N:0]      mismatch_count;
  logic [N-1:0]    first_mismatch_idx;

  // Second stimulus port set shared by the SETTLE_CYCLES=0 and =3 builds.
  logic            start_b;
  logic [TT_W-1:0] expected_b;
  logic [N-1:0]    x_out0, x_out3;
  logic            dut_out0, dut_out3;
  logic            busy0, busy3, done0, done3, match0, match3;
  logic [TT_W-1:0] tt0, tt3;
  logic [N:0]      cnt0, cnt3;
  logic [N-1:0]    first0, first3;

  int              mode;
  logic [TT_W-1:0] src_tt;
  int              tests = 0;
  int              fails = 0;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic net(input logic [N-1:0] x);
    return maj(x[0], x[1], maj(x[3], maj(x[2], x[4], maj(x[3], x[5], x[6])), maj(x[0], x[2], x[5])));
  endfunction

  // mode 0: majority network, 1: output tied low, 2: arbitrary table
  function automatic logic src_bit(input int m, input logic [TT_W-1:0] t, input logic [N-1:0] x);
    if (m == 0) return net(x);
    if (m == 1) return 1'b0;
    return t[x];
  endfunction

  assign dut_out  = src_bit(mode, src_tt, x_out);
  assign dut_out0 = net(x_out0);
  assign dut_out3 = net(x_out3);

  mig_tt_sweeper #(.NUM_INPUTS(N), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected_tt(expected_tt),
    .x_out(x_out), .dut_out(dut_out), .busy(busy), .done(done), .truth_table(truth_table),
    .match(match), .mismatch_count(mismatch_count), .first_mismatch_idx(first_mismatch_idx));

  mig_tt_sweeper #(.NUM_INPUTS(N), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .expected_tt(expected_b),
    .x_out(x_out0), .dut_out(dut_out0), .busy(busy0), .done(done0), .truth_table(tt0),
    .match(match0), .mismatch_count(cnt0), .first_mismatch_idx(first0));

  mig_tt_sweeper #(.NUM_INPUTS(N), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .expected_tt(expected_b),
    .x_out(x_out3), .dut_out(dut_out3), .busy(busy3), .done(done3), .truth_table(tt3),
    .match(match3), .mismatch_count(cnt3), .first_mismatch_idx(first3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [TT_W-1:0] act, input logic [TT_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference scoring straight from the rules: count differing bits, lowest one wins.
  function automatic void ref_score(input logic [TT_W-1:0] got, input logic [TT_W-1:0] exp,
                                    output int cnt, output int first, output logic m);
    cnt = 0;
    first = -1;
    for (int i = 0; i < TT_W; i++) begin
      if (got[i] != exp[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) first = 0;
    m = (cnt == 0);
  endfunction

  function automatic logic [TT_W-1:0] rand_tt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  typedef struct {
    string           name;
    int              mode;
    logic [TT_W-1:0] src;
    logic [TT_W-1:0] exp_tt;
    bit              with_abort;
    logic [TT_W-1:0] want_tt;
    int              want_cnt;
    int              want_first;
    logic            want_match;
  } vec_t;

  vec_t vecs[6];

  // Full sweep on the SETTLE_CYCLES=1 instance; disturbs expected_tt and start mid-run.
  task automatic sweep_main(input vec_t v);
    int cyc;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    mode        = v.mode;
    src_tt      = v.src;
    expected_tt = v.exp_tt;
    start       = 1'b1;
    abort       = v.with_abort;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    cyc = 0;
    seen = 1'b0;
    busy_ok = busy;
    while (!seen && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (cyc == 10) expected_tt = ~v.exp_tt;
      start = (cyc == 50);
    end
    start = 1'b0;
    check({v.name, "_done_cycle"}, seen ? cyc : -1, 257);
    check({v.name, "_busy_during"}, busy_ok, 1'b1);
    check({v.name, "_busy_at_done"}, busy, 1'b0);
    check({v.name, "_tt"}, truth_table, v.want_tt);
    check({v.name, "_count"}, mismatch_count, v.want_cnt);
    check({v.name, "_first"}, first_mismatch_idx, v.want_first);
    check({v.name, "_match"}, match, v.want_match);
    @(negedge clk);
    check({v.name, "_done_pulse"}, done, 1'b0);
    check({v.name, "_x_idle"}, x_out, '0);
  endtask

  initial begin
    int         c;
    int         f;
    logic       m;
    logic [TT_W-1:0] mask;
    bit         mono0, mono3, done_seen;
    int         prev0, prev3, max0, max3, cyc0, cyc3;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected_tt = '0;
    start_b = 1'b0; expected_b = GOLDEN; mode = 0; src_tt = '0;

    #1;
    check("rst_x", x_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tt", truth_table, '0);
    check("rst_match", match, 1'b0);
    check("rst_count", mismatch_count, '0);
    check("rst_first", first_mismatch_idx, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{"golden", 0, '0, GOLDEN, 1'b0, GOLDEN, 0, 0, 1'b1};
    vecs[1] = '{"bit5_err", 0, '0, GOLDEN ^ (128'd1 << 5), 1'b0, GOLDEN, 1, 5, 1'b0};
    vecs[2] = '{"all_wrong", 1, '0, '1, 1'b1, '0, 128, 0, 1'b0};
    for (int i = 3; i < 6; i++) begin
      vecs[i].name       = $sformatf("rand%0d", i);
      vecs[i].mode       = 2;
      vecs[i].src        = rand_tt();
      mask               = (i == 3) ? rand_tt() : (i == 4) ? (rand_tt() & rand_tt() & rand_tt()) : '0;
      vecs[i].exp_tt     = vecs[i].src ^ mask;
      vecs[i].with_abort = 1'b0;
      vecs[i].want_tt    = vecs[i].src;
      ref_score(vecs[i].src, vecs[i].exp_tt, c, f, m);
      vecs[i].want_cnt   = c;
      vecs[i].want_first = f;
      vecs[i].want_match = m;
    end

    for (int i = 0; i < 6; i++) sweep_main(vecs[i]);

    // Abort at cycle 100 after an ignored restart at cycle 50.
    @(negedge clk);
    mode = 0;
    expected_tt = GOLDEN ^ (128'd1 << 5);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start = (cyc == 50);
      abort = (cyc == 100);
    end
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    mask = '0;
    for (int i = 0; i < 50; i++) mask[i] = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_match", match, 1'b0);
    check("abort_x", x_out, '0);
    check("abort_tt_partial", truth_table, GOLDEN & mask);
    check("abort_count", mismatch_count, 1);
    check("abort_first", first_mismatch_idx, 5);
    done_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("abort_stays_idle", done_seen, 1'b0);

    // Asynchronous reset at cycle 120 of a sweep.
    @(negedge clk);
    expected_tt = GOLDEN;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (120) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_x", x_out, '0);
    check("arst_tt", truth_table, '0);
    check("arst_count", mismatch_count, '0);
    check("arst_first", first_mismatch_idx, '0);
    check("arst_match", match, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep_main(vecs[0]);

    // SETTLE_CYCLES=0 and =3 builds swept side by side.
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    mono0 = 1'b1; mono3 = 1'b1;
    prev0 = int'(x_out0); prev3 = int'(x_out3);
    max0 = prev0; max3 = prev3;
    cyc0 = -1; cyc3 = -1;
    for (int cyc = 1; cyc <= 700 && (cyc0 < 0 || cyc3 < 0); cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc0 < 0) begin
        if (done0) cyc0 = cyc;
        else begin
          if (int'(x_out0) != prev0 && int'(x_out0) != prev0 + 1) mono0 = 1'b0;
          prev0 = int'(x_out0);
          if (prev0 > max0) max0 = prev0;
        end
      end
      if (cyc3 < 0) begin
        if (done3) cyc3 = cyc;
        else begin
          if (int'(x_out3) != prev3 && int'(x_out3) != prev3 + 1) mono3 = 1'b0;
          prev3 = int'(x_out3);
          if (prev3 > max3) max3 = prev3;
        end
      end
    end
    check("s0_done_cycle", cyc0, 129);
    check("s3_done_cycle", cyc3, 513);
    check("s0_x_monotonic", mono0, 1'b1);
    check("s3_x_monotonic", mono3, 1'b1);
    check("s0_x_max", max0, 127);
    check("s3_x_max", max3, 127);
    check("s0_tt", tt0, GOLDEN);
    check("s3_tt", tt3, GOLDEN);
    check("s0_match", match0, 1'b1);
    check("s3_match", match3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
